// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state types and baud divisor helper
package uart_pkg;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    // Rounded clock-cycles-per-bit
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - small synchronous FIFO holding received bytes
module uart_rx_fifo #(
    parameter int AW = 2,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit tells full from empty once the indices wrap
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_com_port.sv
// rtl/uart_com_port.sv - 8N1 serial endpoint behind the memory controller COM registers
module uart_com_port
    import uart_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int BAUD    = 115200,
    parameter int FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    input  logic       rx_ack,
    output logic       rx_overrun,
    output logic       rx_frame_err,
    input  logic       uart_rxd,
    output logic       uart_txd
);

    localparam int DIV  = baud_div(CLK_HZ, BAUD);
    localparam int CW   = $clog2(DIV) + 1;
    localparam int HALF = DIV / 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_ready <= 1'b1;
            uart_txd <= STOP_LEVEL;
        end else begin
            case (tx_state)
                T_IDLE: begin
                    if (tx_start) begin
                        tx_shift <= tx_data;
                        tx_cnt   <= '0;
                        tx_ready <= 1'b0;
                        uart_txd <= START_LEVEL;
                        tx_state <= T_START;
                    end
                end
                T_START: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        uart_txd <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_state <= T_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                T_DATA: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == BIT_LAST) begin
                            uart_txd <= STOP_LEVEL;
                            tx_state <= T_STOP;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            uart_txd <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                T_STOP: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt   <= '0;
                        tx_ready <= 1'b1;
                        tx_state <= T_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    // Synchroniser plus one more flop for falling-edge detection
    logic rxd_meta, rxd_sync, rxd_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    rx_state_t     rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state     <= R_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_push      <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_push      <= 1'b0;
            rx_frame_err <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    if (rxd_prev && !rxd_sync) begin
                        rx_cnt   <= '0;
                        rx_state <= R_START;
                    end
                end
                R_START: begin
                    if (rx_cnt == CNT_MID) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rxd_sync ? R_IDLE : R_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                R_DATA: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rxd_sync, rx_shift[7:1]};
                        if (rx_bit == BIT_LAST) rx_state <= R_STOP;
                        else                    rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                R_STOP: begin
                    // Leave mid stop bit so a back-to-back start edge is seen
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt <= '0;
                        if (rxd_sync == STOP_LEVEL) rx_push      <= 1'b1;
                        else                        rx_frame_err <= 1'b1;
                        rx_state <= R_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    logic rx_ack_q;
    logic rx_pop;
    logic fifo_full;
    logic fifo_empty;

    assign rx_pop   = rx_ack & ~rx_ack_q;
    assign rx_ready = ~fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ack_q   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_ack_q <= rx_ack;
            if (rx_push && fifo_full && !rx_pop) rx_overrun <= 1'b1;
        end
    end

    uart_rx_fifo #(
        .AW (FIFO_AW),
        .DW (8)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (rx_pop),
        .head_data (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_uart_com_port.sv
// tb/tb_uart_com_port.sv - self-checking bench for uart_com_port
module tb_uart_com_port;

    localparam int DIV   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_ack = 1'b0;
    logic       rx_overrun;
    logic       rx_frame_err;
    logic       uart_rxd = 1'b1;
    logic       uart_txd;

    int checks   = 0;
    int failures = 0;
    int fe_cnt   = 0;

    logic [7:0] model_q[$];
    logic       model_overrun = 1'b0;

    uart_com_port #(
        .CLK_HZ  (16),
        .BAUD    (1),
        .FIFO_AW (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .rx_ack       (rx_ack),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err),
        .uart_rxd     (uart_rxd),
        .uart_txd     (uart_txd)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rx_frame_err === 1'b1) fe_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (uart_txd !== 1'b1)     begin failures++; $display("FAIL reset_txd got=%b exp=1", uart_txd); end
        checks++; if (tx_ready !== 1'b1)     begin failures++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
        checks++; if (rx_ready !== 1'b0)     begin failures++; $display("FAIL reset_rx_ready got=%b exp=0", rx_ready); end
        checks++; if (rx_data !== 8'h00)     begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        checks++; if (rx_overrun !== 1'b0)   begin failures++; $display("FAIL reset_overrun got=%b exp=0", rx_overrun); end
        checks++; if (rx_frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", rx_frame_err); end
    endtask

    // Expected line: start bit, 8 data bits LSB first, stop bit, each DIV cycles
    task automatic test_tx(input logic [7:0] d, input bit busy_poke);
        logic [9:0] frame;
        logic       exp_bit;
        frame    = {1'b1, d, 1'b0};
        tx_data  = d;
        tx_start = 1'b1;
        for (int k = 1; k <= 10 * DIV; k++) begin
            tick();
            if (k == 1) tx_start = 1'b0;
            if (busy_poke && k == 50) begin tx_data = 8'h3C; tx_start = 1'b1; end
            if (busy_poke && k == 51) tx_start = 1'b0;
            exp_bit = frame[(k - 1) / DIV];
            checks++; if (uart_txd !== exp_bit) begin failures++; $display("FAIL tx_bit d=%h cycle=%0d got=%b exp=%b", d, k, uart_txd, exp_bit); end
            checks++; if (tx_ready !== 1'b0)    begin failures++; $display("FAIL tx_busy d=%h cycle=%0d got=%b exp=0", d, k, tx_ready); end
        end
        tick();
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL tx_ready_end d=%h got=%b exp=1", d, tx_ready); end
        checks++; if (uart_txd !== 1'b1) begin failures++; $display("FAIL tx_idle_end d=%h got=%b exp=1", d, uart_txd); end
    endtask

    // Drives one frame on uart_rxd; reports the frame cycle where rx_ready rose
    task automatic send_frame(input logic [7:0] d, input logic stop, output int rise_at);
        logic [9:0] frame;
        logic       prev;
        frame   = {stop, d, 1'b0};
        rise_at = -1;
        prev    = rx_ready;
        for (int i = 0; i < 10 * DIV; i++) begin
            uart_rxd = frame[i / DIV];
            tick();
            if (!prev && rx_ready && rise_at < 0) rise_at = i;
            prev = rx_ready;
        end
        uart_rxd = 1'b1;
        if (stop) begin
            if (model_q.size() < DEPTH) model_q.push_back(d);
            else                        model_overrun = 1'b1;
        end
    endtask

    task automatic ack_pop(input int hold);
        logic [7:0] exp_head;
        exp_head = (model_q.size() > 0) ? model_q[0] : 8'h00;
        checks++; if (rx_data !== exp_head) begin failures++; $display("FAIL ack_head got=%h exp=%h", rx_data, exp_head); end
        rx_ack = 1'b1;
        for (int i = 0; i < hold; i++) tick();
        rx_ack = 1'b0;
        tick();
        if (model_q.size() > 0) void'(model_q.pop_front());
        exp_head = (model_q.size() > 0) ? model_q[0] : 8'h00;
        checks++; if (rx_ready !== (model_q.size() > 0)) begin failures++; $display("FAIL ack_ready got=%b exp=%b", rx_ready, model_q.size() > 0); end
        checks++; if (rx_data !== exp_head) begin failures++; $display("FAIL ack_next got=%h exp=%h", rx_data, exp_head); end
    endtask

    task automatic test_rx_single();
        int rise;
        send_frame(8'h5A, 1'b1, rise);
        checks++; if (rise < 9 * DIV || rise > 9 * DIV + DIV / 2 + 2 + DIV / 2) begin failures++; $display("FAIL rx_latency got=%0d exp=%0d..%0d", rise, 9 * DIV, 9 * DIV + DIV + 2); end
        checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL rx_ready got=%b exp=1", rx_ready); end
        checks++; if (rx_data !== 8'h5A) begin failures++; $display("FAIL rx_data got=%h exp=5a", rx_data); end
        ack_pop(5);
        checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL rx_held_ack got=%b exp=0", rx_ready); end
    endtask

    task automatic test_rx_random();
        int rise;
        logic [7:0] d;
        for (int n = 0; n < 3; n++) begin
            d = 8'($urandom);
            send_frame(d, 1'b1, rise);
            for (int i = 0; i < 3; i++) tick();
            checks++; if (rx_data !== model_q[0]) begin failures++; $display("FAIL rx_rand got=%h exp=%h", rx_data, model_q[0]); end
            ack_pop(1 + int'($urandom_range(5)));
        end
    endtask

    task automatic test_fifo_overrun();
        int rise;
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, rise);
        for (int i = 0; i < 4; i++) tick();
        checks++; if (rx_overrun !== model_overrun) begin failures++; $display("FAIL overrun got=%b exp=%b", rx_overrun, model_overrun); end
        checks++; if (rx_ready !== 1'b1)            begin failures++; $display("FAIL overrun_ready got=%b exp=1", rx_ready); end
        for (int i = 0; i < DEPTH; i++) ack_pop(1 + int'($urandom_range(3)));
        checks++; if (rx_ready !== 1'b0)      begin failures++; $display("FAIL drained_ready got=%b exp=0", rx_ready); end
        checks++; if (rx_overrun !== 1'b1)    begin failures++; $display("FAIL overrun_sticky got=%b exp=1", rx_overrun); end
    endtask

    task automatic test_frame_err();
        int rise;
        int fe0;
        fe0 = fe_cnt;
        send_frame(8'($urandom), 1'b0, rise);
        for (int i = 0; i < 2 * DIV; i++) tick();
        checks++; if (fe_cnt - fe0 !== 1) begin failures++; $display("FAIL frame_err_pulses got=%0d exp=1", fe_cnt - fe0); end
        checks++; if (rx_ready !== 1'b0)  begin failures++; $display("FAIL frame_err_ready got=%b exp=0", rx_ready); end
    endtask

    task automatic test_glitch();
        int fe0;
        fe0 = fe_cnt;
        uart_rxd = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        uart_rxd = 1'b1;
        for (int i = 0; i < 12 * DIV; i++) tick();
        checks++; if (rx_ready !== 1'b0)  begin failures++; $display("FAIL glitch_ready got=%b exp=0", rx_ready); end
        checks++; if (fe_cnt !== fe0)     begin failures++; $display("FAIL glitch_frame_err got=%0d exp=%0d", fe_cnt, fe0); end
    endtask

    task automatic test_reset_mid_frame();
        tx_data  = 8'($urandom);
        tx_start = 1'b1;
        uart_rxd = 1'b0;
        tick();
        tx_start = 1'b0;
        for (int i = 0; i < 36; i++) tick();
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL pre_reset_busy got=%b exp=0", tx_ready); end
        rst      = 1'b1;
        uart_rxd = 1'b1;
        tick();
        rst = 1'b0;
        model_q.delete();
        model_overrun = 1'b0;
        checks++; if (uart_txd !== 1'b1)   begin failures++; $display("FAIL rst_mid_txd got=%b exp=1", uart_txd); end
        checks++; if (tx_ready !== 1'b1)   begin failures++; $display("FAIL rst_mid_tx_ready got=%b exp=1", tx_ready); end
        checks++; if (rx_overrun !== 1'b0) begin failures++; $display("FAIL rst_mid_overrun got=%b exp=0", rx_overrun); end
        for (int i = 0; i < 12 * DIV; i++) tick();
        checks++; if (rx_ready !== 1'b0)   begin failures++; $display("FAIL rst_mid_rx_lost got=%b exp=0", rx_ready); end
        checks++; if (uart_txd !== 1'b1)   begin failures++; $display("FAIL rst_mid_txd_idle got=%b exp=1", uart_txd); end
    endtask

    initial begin
        test_reset();
        test_tx(8'hA5, 1'b1);
        test_tx(8'($urandom), 1'b0);
        test_tx(8'($urandom), 1'b1);
        test_rx_single();
        test_rx_random();
        test_fifo_overrun();
        test_frame_err();
        test_glitch();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
